// File: rtl/serial_receiver.sv
// UART receiver (8N1) with ready/valid output buffer and one-cycle error pulses.
// Define SERIAL_RECEIVER_PARITY_EN to receive 8E1 frames with parity checking.
module serial_receiver #(
    parameter int unsigned CYCLES_PER_BIT = 417
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_framing_error,
    output logic       rx_parity_error,
    output logic       rx_overrun
);

    localparam int unsigned CntW = $clog2(CYCLES_PER_BIT + 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(CYCLES_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit = CntW'(CYCLES_PER_BIT);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
`ifdef SERIAL_RECEIVER_PARITY_EN
        StWaitIdle = 3'd4,
        StParity   = 3'd5
`else
        StWaitIdle = 3'd4
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            expire;
    logic            par_bad;

    assign rx_s   = sync_q[1];
    // Counter is loaded with N and acts on the cycle it reads 1, giving an N-cycle interval.
    assign expire = (cnt_q == CntW'(1));

`ifdef SERIAL_RECEIVER_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    assign par_bad         = ^{shift_q, par_q};
    assign rx_parity_error = perr_q;
`else
    assign par_bad         = 1'b0;
    assign rx_parity_error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!rx_s) state_d = StStart;
            StStart:    if (expire) state_d = rx_s ? StIdle : StData;
            StData: begin
                if (expire && (bit_q == 3'd7)) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef SERIAL_RECEIVER_PARITY_EN
            StParity:   if (expire) state_d = StStop;
`endif
            StStop:     if (expire) state_d = rx_s ? StIdle : StWaitIdle;
            StWaitIdle: if (rx_s) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (valid_q && rx_data_ready) valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    cnt_d = HalfBit;
                    bit_d = 3'd0;
                end
            end
            StStart: begin
                if (expire && !rx_s) cnt_d = FullBit;
            end
            StData: begin
                if (expire) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = FullBit;
                end
            end
`ifdef SERIAL_RECEIVER_PARITY_EN
            StParity: begin
                if (expire) begin
                    par_d = rx_s;
                    cnt_d = FullBit;
                end
            end
`endif
            StStop: begin
                if (expire) begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (par_bad) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                        perr_d = 1'b1;
`endif
                    end else if (!valid_q || rx_data_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], serial_rx};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SERIAL_RECEIVER_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
`endif

    assign rx_data          = data_q;
    assign rx_data_valid    = valid_q;
    assign rx_framing_error = ferr_q;
    assign rx_overrun       = ovr_q;

endmodule
